// File: rtl/nes_video_gen.sv
// nes_video_gen: NES video output stage.
// Converts PPU palette indices plus PPU beam counters into CW-bit RGB with
// sync and blanking. A lock FSM follows the PPU counters when they carry
// frame starts and falls back to internal free-running timing otherwise.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pix_ce              pixel strobe; all state except palette writes steps on it
//   color               PPU palette index
//   count_h, count_v    PPU beam counters (count_v 511 -> 0 marks a frame start)
//   region              0/3 NTSC, 1 PAL, 2 Dendy
//   crop_*              per-edge crop of the visible area
//   emphasis            {B,G,R} emphasis bits
//   pal_wr/addr/wdata   palette write port
//   pal_rdata           palette readback at pal_addr (1 cycle, when pix_ce low)
//   locked, hold_reset  timing status
//   hs, vs, hblank, vblank, de, r, g, b  video out (2 pix_ce after color)
module nes_video_gen #(
  parameter int         CW          = 8,
  parameter int         H_TOTAL     = 341,
  parameter int         H_ACTIVE    = 256,
  parameter int         H_VIS       = 280,
  parameter int         V_ACTIVE    = 240,
  parameter int         HS_START    = 278,
  parameter int         HS_LEN      = 25,
  parameter int         MISS_FRAMES = 3,
  parameter logic [5:0] PAD_COLOR   = 6'h3F
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pix_ce,
  input  logic [5:0]      color,
  input  logic [8:0]      count_h,
  input  logic [8:0]      count_v,
  input  logic [1:0]      region,
  input  logic [4:0]      crop_top,
  input  logic [4:0]      crop_bottom,
  input  logic [4:0]      crop_left,
  input  logic [4:0]      crop_right,
  input  logic [2:0]      emphasis,
  input  logic            pal_wr,
  input  logic [5:0]      pal_addr,
  input  logic [3*CW-1:0] pal_wdata,
  output logic [3*CW-1:0] pal_rdata,
  output logic            locked,
  output logic            hold_reset,
  output logic            hs,
  output logic            vs,
  output logic            hblank,
  output logic            vblank,
  output logic            de,
  output logic [CW-1:0]   r,
  output logic [CW-1:0]   g,
  output logic [CW-1:0]   b
);

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_SEEK   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [8:0]  H_LAST     = 9'(H_TOTAL - 1);
  localparam logic [10:0] H_ACTIVE_X = 11'(H_ACTIVE);
  localparam logic [10:0] H_VIS_X    = 11'(H_VIS);
  localparam logic [10:0] V_ACTIVE_X = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START_X = 11'(HS_START);
  localparam logic [10:0] HS_END_X   = 11'(HS_START + HS_LEN);
  localparam logic [3:0]  MISS_L     = 4'(MISS_FRAMES);

  // Default 2C02 palette, 8 bits per channel, {R,G,B}.
  localparam logic [23:0] NES_PAL [64] = '{
    24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
    24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
    24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
    24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
    24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
    24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
    24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
    24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
  };

  typedef logic [3*CW-1:0] pal_t [64];

  // Bit replication: truncates for CW < 8, fills low bits for CW > 8.
  function automatic logic [CW-1:0] scale8(input logic [7:0] x);
    logic [CW-1:0] y;
    y = '0;
    for (int i = 0; i < CW; i++) y[CW-1-i] = x[7-(i%8)];
    return y;
  endfunction

  function automatic pal_t default_pal();
    pal_t p;
    for (int i = 0; i < 64; i++)
      p[i] = {scale8(NES_PAL[i][23:16]), scale8(NES_PAL[i][15:8]), scale8(NES_PAL[i][7:0])};
    return p;
  endfunction

  function automatic logic [CW-1:0] dim(input logic [CW-1:0] x);
    return (x >> 1) + (x >> 2);
  endfunction

  // ---------------- timing ----------------
  logic [8:0] h, v, prev_v, v_last, vs_start, hc, vc;
  logic [1:0] state;
  logic [3:0] miss;
  logic       frame_start, h_wrap, v_wrap;

  always_comb begin
    v_last   = 9'd261;
    vs_start = 9'd243;
    case (region)
      2'd1:    begin v_last = 9'd311; vs_start = 9'd270; end
      2'd2:    begin v_last = 9'd311; vs_start = 9'd290; end
      default: ;
    endcase
  end

  assign frame_start = (prev_v == 9'd511) && (count_v == 9'd0);
  assign h_wrap      = (h == H_LAST);
  assign v_wrap      = h_wrap && (v == v_last);
  assign hc          = (state == ST_LOCKED) ? count_h : h;
  assign vc          = (state == ST_LOCKED) ? count_v : v;

  always_ff @(posedge clk) begin
    if (reset) begin
      h      <= '0;
      v      <= '0;
      prev_v <= '0;
    end else if (pix_ce) begin
      prev_v <= count_v;
      if (frame_start) begin
        h <= '0;
        v <= '0;
      end else if (h_wrap) begin
        h <= '0;
        v <= v_wrap ? 9'd0 : v + 9'd1;
      end else begin
        h <= h + 9'd1;
      end
    end
  end

  // An internal wrap only happens when the PPU failed to deliver a frame
  // start within one internal frame, since a frame start rezeroes h/v.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_FREE;
      miss   <= '0;
      locked <= 1'b0;
    end else if (pix_ce) begin
      locked <= (state == ST_LOCKED);
      case (state)
        ST_FREE: state <= ST_SEEK;
        ST_SEEK: if (frame_start) begin
          state <= ST_LOCKED;
          miss  <= '0;
        end
        ST_LOCKED: begin
          if (frame_start) begin
            miss <= '0;
          end else if (v_wrap) begin
            if (miss + 4'd1 >= MISS_L) begin
              state <= ST_FREE;
              miss  <= '0;
            end else begin
              miss <= miss + 4'd1;
            end
          end
        end
        default: state <= ST_FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                  hold_reset <= 1'b1;
    else if (pix_ce && h == 9'd0 && v == 9'd0)  hold_reset <= 1'b0;
  end

  // ---------------- stage 0: blanking, sync, index ----------------
  logic [10:0] hc_x, vc_x, crop_l, crop_r, crop_t, crop_b;
  logic        hb0, vb0, hs0, vs_hit, pad;
  logic [5:0]  idx0;

  assign hc_x   = {2'b00, hc};
  assign vc_x   = {2'b00, vc};
  assign crop_l = {6'd0, crop_left};
  assign crop_r = {6'd0, crop_right};
  assign crop_t = {6'd0, crop_top};
  assign crop_b = {6'd0, crop_bottom};

  // The over-crop term also covers the subtraction underflowing.
  assign hb0    = (crop_l + crop_r > H_VIS_X) || (hc_x < crop_l) || (hc_x >= H_VIS_X - crop_r);
  assign vb0    = (crop_t + crop_b > V_ACTIVE_X) || (vc_x < crop_t) || (vc_x >= V_ACTIVE_X - crop_b);
  assign hs0    = (hc_x >= HS_START_X) && (hc_x < HS_END_X);
  assign vs_hit = (vc >= vs_start) && (vc < vs_start + 9'd3);
  assign pad    = (hc_x >= H_ACTIVE_X) && (hc_x < H_VIS_X);
  assign idx0   = pad ? PAD_COLOR : color;

  // ---------------- palette RAM ----------------
  logic [3*CW-1:0] pal_mem [64] = default_pal();
  logic [3*CW-1:0] rd_data, rgb1;
  logic [5:0]      rd_addr;

  assign rd_addr = pix_ce ? idx0 : pal_addr;
  assign rd_data = pal_mem[rd_addr];

  always_ff @(posedge clk) begin
    if (pal_wr) pal_mem[pal_addr] <= pal_wdata;
  end

  // A write steals the read port; on a collision stage 1 keeps its RGB.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb1      <= '0;
      pal_rdata <= '0;
    end else if (!pal_wr) begin
      if (pix_ce) rgb1      <= rd_data;
      else        pal_rdata <= rd_data;
    end
  end

  // ---------------- stage 1 ----------------
  logic [3:0] idx1;
  logic [2:0] emph1;
  logic       hb1, vb1, hs1, vs1;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx1  <= '0;
      emph1 <= '0;
      hb1   <= 1'b0;
      vb1   <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
    end else if (pix_ce) begin
      idx1  <= idx0[3:0];
      emph1 <= emphasis;
      hb1   <= hb0;
      vb1   <= vb0;
      hs1   <= hs0;
      if (hc_x == HS_START_X) vs1 <= vs_hit;
    end
  end

  // ---------------- stage 2: emphasis, outputs ----------------
  logic emph_on, all3, dim_r, dim_g, dim_b;

  assign emph_on = (idx1 < 4'hE) && (emph1 != 3'b000);
  assign all3    = (emph1 == 3'b111);
  assign dim_r   = emph_on && (all3 || !emph1[0]);
  assign dim_g   = emph_on && (all3 || !emph1[1]);
  assign dim_b   = emph_on && (all3 || !emph1[2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r      <= '0;
      g      <= '0;
      b      <= '0;
      hblank <= 1'b0;
      vblank <= 1'b0;
      de     <= 1'b0;
      hs     <= 1'b0;
      vs     <= 1'b0;
    end else if (pix_ce) begin
      r      <= dim_r ? dim(rgb1[3*CW-1:2*CW]) : rgb1[3*CW-1:2*CW];
      g      <= dim_g ? dim(rgb1[2*CW-1:CW])   : rgb1[2*CW-1:CW];
      b      <= dim_b ? dim(rgb1[CW-1:0])      : rgb1[CW-1:0];
      hblank <= hb1;
      vblank <= vb1;
      de     <= ~hb1 & ~vb1;
      hs     <= hs1;
      vs     <= vs1;
    end
  end

endmodule

// File: tb/tb_nes_video_gen.sv
// Directed bench for nes_video_gen. A short line (24 pixels) keeps whole
// internal frames affordable; line counts per region are unchanged.
module tb_nes_video_gen;
  localparam int HT = 24;

  logic        clk = 1'b0;
  logic        reset, pix_ce, pal_wr;
  logic [5:0]  color, pal_addr;
  logic [8:0]  count_h, count_v;
  logic [1:0]  region;
  logic [4:0]  crop_top, crop_bottom, crop_left, crop_right;
  logic [2:0]  emphasis;
  logic [23:0] pal_wdata, pal_rdata;
  logic        locked, hold_reset, hs, vs, hblank, vblank, de;
  logic [7:0]  r, g, b;

  int n_cmp = 0;
  int n_bad = 0;
  int k, gap;

  nes_video_gen #(
    .CW(8), .H_TOTAL(HT), .H_ACTIVE(12), .H_VIS(16), .V_ACTIVE(240),
    .HS_START(18), .HS_LEN(4), .MISS_FRAMES(3), .PAD_COLOR(6'h3F)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .color(color),
    .count_h(count_h), .count_v(count_v), .region(region),
    .crop_top(crop_top), .crop_bottom(crop_bottom),
    .crop_left(crop_left), .crop_right(crop_right),
    .emphasis(emphasis), .pal_wr(pal_wr), .pal_addr(pal_addr),
    .pal_wdata(pal_wdata), .pal_rdata(pal_rdata), .locked(locked),
    .hold_reset(hold_reset), .hs(hs), .vs(vs), .hblank(hblank),
    .vblank(vblank), .de(de), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [23:0] d);
    pal_wr = 1'b1; pal_addr = a; pal_wdata = d;
    tick();
    pal_wr = 1'b0;
  endtask

  // Hold one beam position/colour for two pix_ce so the outputs show it.
  task automatic probe(input int hh, input int vv, input logic [5:0] c);
    count_h = 9'(hh); count_v = 9'(vv); color = c;
    tick(); tick();
  endtask

  // Rise-to-rise distance of hs (sel=0) or vs (sel=1); -1 on timeout.
  task automatic rise_gap(input bit sel, input int bound, output int gp);
    logic p, cur;
    int   n;
    gp = -1;
    p  = sel ? vs : hs;
    n  = 0;
    while (n < bound) begin
      tick(); n++;
      cur = sel ? vs : hs;
      if (cur && !p) break;
      p = cur;
    end
    if (n >= bound) return;
    p = 1'b1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      cur = sel ? vs : hs;
      if (cur && !p) begin gp = i; return; end
      p = cur;
    end
  endtask

  initial begin
    reset = 1'b1; pix_ce = 1'b1; color = '0; count_h = '0; count_v = '0;
    region = '0; crop_top = '0; crop_bottom = '0; crop_left = '0; crop_right = '0;
    emphasis = '0; pal_wr = 1'b0; pal_addr = '0; pal_wdata = '0;
    repeat (3) tick();
    chk("rst_sync",   {hs, vs, hblank, vblank, de}, 5'b0);
    chk("rst_rgb",    {r, g, b}, 24'h0);
    chk("rst_rdata",  pal_rdata, 24'h0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_hold",   hold_reset, 1'b1);

    // Palette writes and readback with pix_ce low (timing frozen).
    reset = 1'b0; pix_ce = 1'b0;
    wr(6'h21, 24'hFF8040);
    wr(6'h2E, 24'h123456);
    wr(6'h3F, 24'h0A0B0C);
    wr(6'h05, 24'h204060);
    pal_addr = 6'h21; tick();
    chk("rdata_21", pal_rdata, 24'hFF8040);
    pal_addr = 6'h3F; tick();
    chk("rdata_3f", pal_rdata, 24'h0A0B0C);
    chk("hold_no_ce", hold_reset, 1'b1);

    // First pix_ce at h=v=0 releases hold_reset; then lock.
    pix_ce = 1'b1; tick();
    chk("hold_clear", hold_reset, 1'b0);
    count_v = 9'd511; tick();
    count_v = 9'd0;   tick();
    chk("lock_lag", locked, 1'b0);
    tick();
    chk("lock_2nd", locked, 1'b1);

    // Crop: hblank hc<2 or hc>=14, vblank vc<8 or vc>=232; pad at hc 12..15.
    crop_left = 5'd2; crop_right = 5'd2; crop_top = 5'd8; crop_bottom = 5'd8;
    probe(1, 100, 6'h05);   chk("crop_l_out", {hblank, de}, 2'b10);
    probe(2, 100, 6'h05);   chk("crop_l_in",  {hblank, de}, 2'b01);
    chk("pix_05", {r, g, b}, 24'h204060);
    probe(13, 100, 6'h05);  chk("crop_r_in",  {hblank, de}, 2'b01);
    chk("pad_rgb", {r, g, b}, 24'h0A0B0C);
    probe(14, 100, 6'h05);  chk("crop_r_out", {hblank, de}, 2'b10);
    probe(10, 7, 6'h05);    chk("crop_t_out", {vblank, de}, 2'b10);
    probe(10, 8, 6'h05);    chk("crop_t_in",  {vblank, de}, 2'b01);
    probe(10, 231, 6'h05);  chk("crop_b_in",  {vblank, de}, 2'b01);
    probe(10, 232, 6'h05);  chk("crop_b_out", {vblank, de}, 2'b10);

    // hs high for hc 18..21.
    probe(17, 100, 6'h05);  chk("hs_17", hs, 1'b0);
    probe(18, 100, 6'h05);  chk("hs_18", hs, 1'b1);
    probe(21, 100, 6'h05);  chk("hs_21", hs, 1'b1);
    probe(22, 100, 6'h05);  chk("hs_22", hs, 1'b0);

    // PAL, no crop: vblank from 240, vs lines 270..272 sampled at hc 18.
    crop_left = '0; crop_right = '0; crop_top = '0; crop_bottom = '0;
    region = 2'd1;
    probe(10, 239, 6'h05);  chk("vbl_239", vblank, 1'b0);
    probe(10, 240, 6'h05);  chk("vbl_240", vblank, 1'b1);
    probe(18, 269, 6'h05);  chk("vs_269", vs, 1'b0);
    probe(18, 270, 6'h05);  chk("vs_270", vs, 1'b1);
    probe(5, 300, 6'h05);   chk("vs_hold", vs, 1'b1);
    probe(18, 272, 6'h05);  chk("vs_272", vs, 1'b1);
    probe(18, 273, 6'h05);  chk("vs_273", vs, 1'b0);

    // Emphasis; dim(x) = x/2 + x/4 truncated.
    emphasis = 3'b001;
    probe(10, 100, 6'h21);  chk("emph_r", {r, g, b}, 24'hFF6030);
    probe(10, 100, 6'h2E);  chk("emph_2e", {r, g, b}, 24'h123456);
    emphasis = 3'b111;
    probe(10, 100, 6'h21);  chk("emph_all", {r, g, b}, 24'hBE6030);
    emphasis = 3'b010;
    probe(10, 100, 6'h21);  chk("emph_g", {r, g, b}, 24'hBE8030);
    emphasis = 3'b000;

    // Write colliding with pix_ce: the pixel repeats the prior RGB.
    color = 6'h05; tick();
    color = 6'h21; pal_wr = 1'b1; pal_addr = 6'h10; pal_wdata = 24'h112233; tick();
    pal_wr = 1'b0; tick();
    chk("wr_collide", {r, g, b}, 24'h204060);
    tick();
    chk("after_coll", {r, g, b}, 24'hFF8040);
    pix_ce = 1'b0; pal_addr = 6'h10; tick();
    chk("rdata_10", pal_rdata, 24'h112233);
    pix_ce = 1'b1;

    // Reset mid-frame while locked, then relock.
    chk("pre_rst_lock", locked, 1'b1);
    reset = 1'b1; tick();
    chk("mid_rst_out", {hs, vs, hblank, vblank, de, r, g, b, pal_rdata}, 53'h0);
    chk("mid_rst_hold", hold_reset, 1'b1);
    chk("mid_rst_lock", locked, 1'b0);
    reset = 1'b0; region = 2'd0; count_v = 9'd511; tick();
    chk("relock_hold", hold_reset, 1'b0);
    count_v = 9'd0; tick();
    chk("relock_lag", locked, 1'b0);
    tick();
    chk("relock", locked, 1'b1);

    // Counters frozen: the third internal wrap (3*262*HT pix_ce after the
    // frame start) drops to FREE, and locked follows one pix_ce later.
    k = 1;
    while (locked && k < 20000) begin tick(); k++; end
    chk("miss_time", k, 3 * 262 * HT + 1);

    rise_gap(1'b0, 100, gap);     chk("hs_period", gap, HT);
    rise_gap(1'b1, 15000, gap);   chk("ntsc_frame", gap, 262 * HT);
    region = 2'd1;
    rise_gap(1'b1, 17000, gap);   chk("pal_frame", gap, 312 * HT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nes_video_gen.md
Name: nes_video_gen

Overview:
- Parametrised successor to the NES video output stage.
- Turns PPU pixel indices plus PPU beam counters into 24-bit-class RGB with sync and blank.
- Adds a lock state machine with configurable miss tolerance, three region modes (NTSC/PAL/Dendy), per-edge overscan crop, a writable/readable palette RAM and generic channel width.
- Sits between the PPU and the video mixer / scandoubler.

Parameters:
- CW, 8, bits per RGB channel output.
- H_TOTAL, 341, pixels per line, counted 0..H_TOTAL-1.
- H_ACTIVE, 256, pixels carrying PPU image data.
- H_VIS, 280, visible width including padding; pixels from H_ACTIVE to H_VIS-1 show PAD_COLOR.
- V_ACTIVE, 240, visible lines.
- HS_START, 278, hc at which HS rises.
- HS_LEN, 25, HS width in pixels.
- MISS_FRAMES, 3, internal frames without a PPU frame start before falling back to free-run; valid range 1..15.
- PAD_COLOR, 6'h3F, palette index used for padding pixels.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pix_ce  in  1  one-cycle pixel strobe; all state except palette writes advances only on pix_ce
- color  in  6  PPU palette index
- count_h  in  9  PPU horizontal counter
- count_v  in  9  PPU vertical counter; 511 followed by 0 marks a frame start
- region  in  2  0 = NTSC (262 lines, vsync 243), 1 = PAL (312 lines, vsync 270), 2 = Dendy (312 lines, vsync 290), 3 = treated as NTSC
- crop_top, crop_bottom  in  5 each  lines removed at top and bottom of the visible area
- crop_left, crop_right  in  5 each  pixels removed at left and right of the visible area
- emphasis  in  3  {B,G,R} emphasis bits
- pal_wr  in  1  palette write strobe
- pal_addr  in  6  palette write/read address
- pal_wdata  in  3*CW  {R,G,B} write data
- pal_rdata  out  3*CW  palette readback at pal_addr; 1-cycle latency, valid when pix_ce is low
- locked  out  1  high when output timing follows the PPU counters
- hold_reset  out  1  high until internal timing reaches line 0, pixel 0 after reset
- hs, vs, hblank, vblank, de  out  1 each  sync and blanking; de = ~hblank & ~vblank
- r, g, b  out  CW each  pixel data

Behaviour:
- Reset values: all outputs 0 except hold_reset = 1. Internal h = v = 0, miss counter 0, state FREE.
- Timing source: hc/vc = internal h/v in FREE and SEEK; hc/vc = count_h/count_v in LOCKED.
- Internal h/v run in every state:
  - h wraps at H_TOTAL-1; v wraps at the region's last line (261 or 311).
  - On a frame start (count_v goes 511 to 0, sampled on pix_ce), h and v are set to 0 on that same pix_ce.
- Lock state machine, evaluated on pix_ce:
  - FREE to SEEK when reset is low.
  - SEEK to LOCKED on a frame start, clearing the miss counter.
  - LOCKED:
    - Each internal wrap of v with no frame start in that frame increments the miss counter.
    - Reaching MISS_FRAMES returns to FREE.
    - Any frame start clears the counter.
  - Reset in any state forces FREE on the next clk edge, abandoning any partial frame.
  - locked = (state == LOCKED), registered.
- hold_reset:
  - Set while reset is high.
  - Cleared on the first pix_ce with reset low and internal h = 0, v = 0.
- Blanking, registered on pix_ce:
  - hblank = (hc < crop_left) or (hc >= H_VIS - crop_right).
  - vblank = (vc < crop_top) or (vc >= V_ACTIVE - crop_bottom).
  - If a crop sum exceeds the dimension, that blank is held permanently high.
- Sync:
  - hs rises at hc = HS_START and falls at hc = HS_START + HS_LEN.
  - vs is updated only at hc = HS_START: high for vc in [vs_start, vs_start+3).
- Pixel pipeline:
  - Stage 0: effective index = PAD_COLOR when H_ACTIVE <= hc < H_VIS, else color; palette RAM read issued.
  - Stage 1: RAM data and the emphasis mask are registered.
  - Stage 2: emphasis applied, outputs registered.
  - Latency is 2 pix_ce from color sample to r/g/b; hblank, vblank, hs, vs and de are delayed to match.
- Palette writes:
  - pal_wr has priority over the lookup read.
  - If pal_wr coincides with pix_ce, that pixel repeats the previous stage-1 RGB.
- Emphasis:
  - Applies only when index[3:0] < 4'hE and emphasis != 0.
  - All three bits set dims all channels; otherwise each channel whose bit is clear is dimmed.
  - Dim value = (x>>1) + (x>>2) at width CW, which cannot overflow.
- Palette RAM initial content is the default palette file; reset does not clear it.

Test Plan:
- Reset, then drive the PPU counters with count_v going 511 to 0 -> locked = 1 on the second pix_ce after that edge; hold_reset clears at h = 0, v = 0.
- Lock, then stop the PPU counters, region = 0, MISS_FRAMES = 3 -> locked falls after 3*262*341 pix_ce; hs period stays 341 pix_ce.
- region = 1, no crop -> vs high for lines 270..272; line count 312; vblank high for vc >= 240.
- crop_left = 8, crop_right = 8, crop_top = 8, crop_bottom = 8 -> de high for hc 8..271 and vc 8..231 only; hc 256..271 output the RGB of palette entry 0x3F.
- Write pal_addr = 0x21 with 0xFF8040, emphasis = 3'b001, color = 0x21 -> r = 0xFF, g = 0x60, b = 0x30 after 2 pix_ce; pal_rdata = 0xFF8040. With color = 0x2E the output is undimmed.
- Assert reset mid-frame while LOCKED -> next cycle all outputs 0, hold_reset = 1, state FREE; relock on the next frame start.
